poly_err_add: RTL and testbench

- Stage directly downstream of multiplier_top in the FV encryption datapath.
- Consumes the product coefficient stream z (p·u mod q) and a signed error coefficient stream e.
- Emits c = (z + e) mod Q, coefficient by coefficient, with its own frame framing (c.last every N coefficients).
- Provides a 2-entry output buffer so the ciphertext consumer can stall without stalling the multiplier by more than one beat.

---
 rtl/poly_err_add.sv | 172 +++++++++++++++++
 tb/tb_poly_err_add.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_err_add.sv
// Purpose: c = (z + e) mod Q per coefficient, with locally generated c.last every N beats.
// Latency: 1 cycle from accepted z/e beat to c when the output buffer is empty or draining.
// Backpressure: 2-entry output skid; the z/e join stalls only when both entries are held.
// Optional: define POLY_ERR_ADD_LAST_CHECK_EN for a sticky z.last/e.last framing check on o_err.
module poly_err_add #(
    parameter int N  = 4,
    parameter int QW = 5,
    parameter int EW = 3,
    parameter int Q  = 29
) (
    input  logic          i_clk,
    input  logic          i_s_rst_n,
    input  logic          i_z_vld,
    output logic          o_z_rdy,
    input  logic          i_z_last,
    input  logic [QW-1:0] i_z_data,
    input  logic          i_e_vld,
    output logic          o_e_rdy,
    input  logic          i_e_last,
    input  logic [EW-1:0] i_e_data,
    output logic          o_c_vld,
    input  logic          i_c_rdy,
    output logic          o_c_last,
    output logic [QW-1:0] o_c_data,
    output logic          o_err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = QW + 2;
    localparam logic [IW-1:0]        LAST_IDX = IW'(N - 1);
    localparam logic signed [SW-1:0] Q_S      = SW'(Q);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t         r_state;
    logic           r_run;
    logic [IW-1:0]  r_idx;
    logic           r_c_vld;
    logic           r_c_last;
    logic [QW-1:0]  r_c_data;
    logic           r_tail_last;
    logic [QW-1:0]  r_tail_data;

    logic                 w_pop;
    logic                 w_can_accept;
    logic                 w_acc;
    logic                 w_is_last;
    logic signed [SW-1:0] w_z_ext;
    logic signed [SW-1:0] w_e_ext;
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_adj;
    logic [QW-1:0]        w_res;

    // r_run keeps both rdy outputs low while in reset and until the first clock after it.
    assign w_pop        = r_c_vld && i_c_rdy;
    assign w_can_accept = (r_state != ST_FULL) || w_pop;
    assign o_z_rdy      = r_run && i_e_vld && w_can_accept;
    assign o_e_rdy      = r_run && i_z_vld && w_can_accept;
    assign w_acc        = r_run && i_z_vld && i_e_vld && w_can_accept;
    assign w_is_last    = (r_idx == LAST_IDX);

    // z is unsigned and below Q; e is sign-extended so the sum spans [-2^(EW-1), 2Q).
    assign w_z_ext = {2'b00, i_z_data};
    assign w_e_ext = {{(SW-EW){i_e_data[EW-1]}}, i_e_data};
    assign w_sum   = w_z_ext + w_e_ext;

    // Single conditional correction brings the sum back into [0, Q-1].
    always_comb begin
        w_adj = w_sum;
        if (w_sum < 0) begin
            w_adj = w_sum + Q_S;
        end else if (w_sum >= Q_S) begin
            w_adj = w_sum - Q_S;
        end
    end

    assign w_res = QW'(w_adj);

    // Coefficient index within the frame; only accepted beats advance it, gaps hold it.
    always_ff @(posedge i_clk or negedge i_s_rst_n) begin
        if (!i_s_rst_n) begin
            r_idx <= '0;
        end else if (w_acc) begin
            r_idx <= w_is_last ? '0 : r_idx + 1'b1;
        end
    end

    // Output skid FSM: the head entry drives c directly, the tail holds the second beat.
    always_ff @(posedge i_clk or negedge i_s_rst_n) begin
        if (!i_s_rst_n) begin
            r_state     <= ST_EMPTY;
            r_run       <= 1'b0;
            r_c_vld     <= 1'b0;
            r_c_last    <= 1'b0;
            r_c_data    <= '0;
            r_tail_last <= 1'b0;
            r_tail_data <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_c_data <= w_res;
                        r_c_last <= w_is_last;
                        r_c_vld  <= 1'b1;
                        r_state  <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({w_acc, w_pop})
                        2'b11: begin
                            r_c_data <= w_res;
                            r_c_last <= w_is_last;
                        end
                        2'b10: begin
                            r_tail_data <= w_res;
                            r_tail_last <= w_is_last;
                            r_state     <= ST_FULL;
                        end
                        2'b01: begin
                            r_c_vld <= 1'b0;
                            r_state <= ST_EMPTY;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // An accept here always coincides with a pop (can_accept).
                    if (w_pop) begin
                        r_c_data <= r_tail_data;
                        r_c_last <= r_tail_last;
                        if (w_acc) begin
                            r_tail_data <= w_res;
                            r_tail_last <= w_is_last;
                        end else begin
                            r_state <= ST_ONE;
                        end
                    end
                end
                default: begin
                    r_c_vld <= 1'b0;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign o_c_vld  = r_c_vld;
    assign o_c_last = r_c_last;
    assign o_c_data = r_c_data;

`ifdef POLY_ERR_ADD_LAST_CHECK_EN
    logic r_err;

    // Sticky flag: either input's last disagrees with the local frame position.
    always_ff @(posedge i_clk or negedge i_s_rst_n) begin
        if (!i_s_rst_n) begin
            r_err <= 1'b0;
        end else if (w_acc && ((i_z_last != w_is_last) || (i_e_last != w_is_last))) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_last_unused;

    assign w_last_unused = i_z_last | i_e_last;
    assign o_err         = 1'b0;
`endif

endmodule

// File: tb/tb_poly_err_add.sv
// Scoreboard bench for poly_err_add: driver pushes hand-computed results, monitor pops on c handshakes.
// Covers reset values, arithmetic boundaries, join, backpressure, framing error flag and mid-frame reset.
// Expected err value follows POLY_ERR_ADD_LAST_CHECK_EN.
module tb_poly_err_add;

    localparam int N  = 4;
    localparam int QW = 5;
    localparam int EW = 3;
    localparam int Q  = 29;
`ifdef POLY_ERR_ADD_LAST_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          z_vld, z_rdy, z_last;
    logic [QW-1:0] z_data;
    logic          e_vld, e_rdy, e_last;
    logic [EW-1:0] e_data;
    logic          c_vld, c_rdy, c_last;
    logic [QW-1:0] c_data;
    logic          err;

    typedef struct {
        int data;
        int last;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;
    int   m_idx   = 0;
    bit   chk_lat = 1'b0;

    poly_err_add #(.N(N), .QW(QW), .EW(EW), .Q(Q)) dut (
        .i_clk     (clk),
        .i_s_rst_n (rst_n),
        .i_z_vld   (z_vld),
        .o_z_rdy   (z_rdy),
        .i_z_last  (z_last),
        .i_z_data  (z_data),
        .i_e_vld   (e_vld),
        .o_e_rdy   (e_rdy),
        .i_e_last  (e_last),
        .i_e_data  (e_data),
        .o_c_vld   (c_vld),
        .i_c_rdy   (c_rdy),
        .o_c_last  (c_last),
        .o_c_data  (c_data),
        .o_err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts accepts and compares every c handshake against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n && z_vld && z_rdy && e_vld && e_rdy) acc_cnt++;
        if (rst_n && c_vld && c_rdy) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got data %0d with empty scoreboard", c_data);
            end else begin
                x = sb_q.pop_front();
                check("c_data", int'(c_data), x.data);
                check("c_last", int'(c_last), x.last);
                if (x.cyc >= 0) check("latency", cyc - x.cyc, 1);
            end
        end
    end

    task automatic send_beat(input int zv, input int ev, input int expd, input bit zl, input bit el);
        int   t;
        exp_t x;
        z_data = zv[QW-1:0];
        e_data = ev[EW-1:0];
        z_last = zl;
        e_last = el;
        z_vld  = 1'b1;
        e_vld  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(z_rdy && e_rdy) && t < 60);
        if (!(z_rdy && e_rdy)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: z=%0d not accepted after %0d cycles", zv, t);
            z_vld = 1'b0;
            e_vld = 1'b0;
        end else begin
            x.data = expd;
            x.last = (m_idx == N - 1) ? 1 : 0;
            x.cyc  = chk_lat ? cyc : -1;
            sb_q.push_back(x);
            m_idx = (m_idx + 1) % N;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int zv, input int ev, input int expd);
        bit l;
        l = (m_idx == N - 1);
        send_beat(zv, ev, expd, l, l);
    endtask

    task automatic idle();
        z_vld = 1'b0;
        e_vld = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int bp_z[8]   = '{3, 4, 5, 6, 7, 8, 9, 10};
    int bp_e[8]   = '{1, 1, 1, 1, -1, -1, -1, -1};
    int bp_exp[8] = '{4, 5, 6, 7, 6, 7, 8, 9};

    initial begin
        int a0;
        int held;
        int t;
        z_vld = 1'b1; e_vld = 1'b1; z_last = 1'b0; e_last = 1'b0;
        z_data = '0; e_data = '0; c_rdy = 1'b1;

        // Reset values, with both inputs valid so rdy gating is exercised.
        gap(3);
        check("rst_z_rdy", int'(z_rdy), 0);
        check("rst_e_rdy", int'(e_rdy), 0);
        check("rst_c_vld", int'(c_vld), 0);
        check("rst_c_last", int'(c_last), 0);
        check("rst_c_data", int'(c_data), 0);
        check("rst_err", int'(err), 0);
        idle();
        rst_n = 1'b1;
        gap(1);

        // Basic frame with latency check.
        chk_lat = 1'b1;
        send(28, 3, 2);
        send(1, -3, 27);
        send(10, 0, 10);
        send(0, -1, 28);
        idle();
        gap(3);
        chk_lat = 1'b0;

        // Join: z valid alone must not be accepted.
        z_data = 5; e_data = '0; z_last = 1'b0; e_last = 1'b0;
        z_vld = 1'b1; e_vld = 1'b0;
        a0 = acc_cnt;
        repeat (3) begin
            @(negedge clk);
            check("join_z_rdy", int'(z_rdy), 0);
            check("join_e_rdy", int'(e_rdy), 1);
        end
        gap(1);
        check("join_no_acc", acc_cnt, a0);
        send(5, 0, 5);
        check("join_one_acc", acc_cnt, a0 + 1);
        send(7, 1, 8);
        send(20, -2, 18);
        send(28, 0, 28);
        idle();
        gap(3);

        // Arithmetic boundaries.
        send(0, -4, 25);
        send(28, 3, 2);
        send(25, 3, 28);
        send(26, 3, 0);
        idle();
        gap(3);

        // Backpressure: only two beats fit while c is stalled.
        c_rdy = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send(bp_z[i], bp_e[i], bp_exp[i]);
                idle();
            end
            begin
                gap(8);
                check("bp_acc", acc_cnt, a0 + 2);
                check("bp_z_rdy", int'(z_rdy), 0);
                check("bp_e_rdy", int'(e_rdy), 0);
                check("bp_c_vld", int'(c_vld), 1);
                check("bp_head", int'(c_data), 4);
                held = c_data;
                gap(4);
                check("bp_held", int'(c_data), held);
                check("bp_acc_hold", acc_cnt, a0 + 2);
                c_rdy = 1'b1;
            end
        join
        gap(4);

        // Framing error: z.last asserted early on beat 3.
        send_beat(1, 0, 1, 1'b0, 1'b0);
        send_beat(2, 0, 2, 1'b0, 1'b0);
        check("err_pre", int'(err), 0);
        send_beat(3, 0, 3, 1'b1, 1'b0);
        check("err_after_b3", int'(err), EXP_ERR);
        send_beat(4, 0, 4, 1'b1, 1'b1);
        idle();
        gap(3);
        check("err_sticky", int'(err), EXP_ERR);

        // Mid-frame asynchronous reset with one entry buffered.
        send(1, 2, 3);
        send(2, 2, 4);
        c_rdy = 1'b0;
        idle();
        #2;
        z_vld = 1'b1; e_vld = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mrst_c_vld", int'(c_vld), 0);
        check("mrst_err", int'(err), 0);
        check("mrst_c_data", int'(c_data), 0);
        check("mrst_z_rdy", int'(z_rdy), 0);
        sb_q.delete();
        m_idx = 0;
        idle();
        gap(1);
        rst_n = 1'b1;
        gap(1);
        c_rdy = 1'b1;
        send(11, 1, 12);
        send(12, -1, 11);
        send(13, 3, 16);
        send(14, -4, 10);
        idle();

        // Drain, bounded.
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        gap(1);
        check("drain_empty", sb_q.size(), 0);
        check("final_err", int'(err), 0);
        check("final_c_vld", int'(c_vld), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
